// File: rtl/decoder_scan_n_pkg.sv
// rtl/decoder_scan_n_pkg.sv - shared mode encodings and output-width helper for decoder_scan_n
//
// Purpose: common definitions used by the decoder_scan_n slice.
//   MODE_DIRECT / MODE_SCAN : encodings of the `mode` input.
//   out_w(sel_w)            : number of decoded lines for a given select width.
package decoder_scan_n_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/decoder_scan_n_scan_prescaler.sv
// rtl/decoder_scan_n_scan_prescaler.sv - programmable prescaler producing the scan step tick
//
// Purpose: counts enabled cycles and flags the cycle on which the count equals `div`,
// giving one step every div+1 enabled cycles.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (count -> 0)
//   clear  in  force count to 0 on the next edge
//   enable in  advance the count (ignored while clear is high)
//   div    in  step period minus 1, sampled every cycle
//   tick   out high while count == div (combinational from the registered count)
module scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = (cnt_q == div);

  // If div drops below the current count the compare simply misses and the
  // count runs on through its natural modulo-2**DIV_W wrap until it matches.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2^N one-hot decoder with direct and auto-scan modes
//
// Purpose: drives row/digit strobes either from `sel` (direct) or from a walking
// index advanced by a programmable prescaler (scan).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   en    in  output enable; 0 forces all lines inactive and freezes idx/prescaler
//   mode  in  0 = direct decode, 1 = auto scan
//   sel   in  direct select index / preset value for load
//   load  in  scan mode: preset the index to sel
//   div   in  scan step period minus 1
//   y     out registered one-hot lines (inverted when ACTIVE_LOW = 1)
//   idx   out registered current index
//   wrap  out one-cycle pulse when the scan index rolls from OUT_W-1 to 0
module decoder_scan_n
  import decoder_scan_n_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load,
  input  logic [DIV_W-1:0]        div,
  output logic [out_w(SEL_W)-1:0] y,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int OUT_W = out_w(SEL_W);
  // XOR mask applied to the active-high decode; also the inactive/reset value of y.
  localparam logic [OUT_W-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] y_q, y_d;

  logic scan_run;
  logic psc_clear;
  logic tick;

  assign scan_run  = en && (mode == MODE_SCAN);
  // Direct mode pins the count at 0 so a later switch to scan starts a fresh period.
  assign psc_clear = en && ((mode == MODE_DIRECT) || load);

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (psc_clear),
    .enable (scan_run),
    .div    (div),
    .tick   (tick)
  );

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT || load) begin
        idx_d = sel;
      end else if (tick) begin
        // OUT_W is a power of two, so the natural SEL_W-bit overflow is the modulo.
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = &idx_q;
      end
    end
    y_d = (en ? (OUT_W'(1) << idx_d) : '0) ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      y_q    <= POL_MASK;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - randomized model-checked bench for decoder_scan_n (three parameter sets)
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] sel_all;
  logic [7:0] div;

  logic [3:0] y0;
  logic [1:0] idx0;
  logic       wrap0;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       wrap1;
  logic [1:0] y2;
  logic [0:0] idx2;
  logic       wrap2;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(2), .DIV_W(8), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_all[1:0]), .load(load),
    .div(div), .y(y0), .idx(idx0), .wrap(wrap0)
  );
  decoder_scan_n #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_all), .load(load),
    .div(div), .y(y1), .idx(idx1), .wrap(wrap1)
  );
  decoder_scan_n #(.SEL_W(1), .DIV_W(8), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_all[0:0]), .load(load),
    .div(div), .y(y2), .idx(idx2), .wrap(wrap2)
  );

  int checks = 0;
  int errors = 0;

  int               sw[3] = '{2, 3, 1};
  int               al[3] = '{0, 1, 0};
  int               m_idx[3];
  int               m_cnt[3];
  bit               m_wrap[3];
  longint unsigned  m_y[3];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned lines(input int k, input bit active, input int index);
    longint unsigned mask, v;
    mask = (64'd1 << (1 << sw[k])) - 64'd1;
    v = active ? (64'd1 << index) : 64'd0;
    if (al[k] != 0) v = ~v & mask;
    return v;
  endfunction

  // Behavioural reference: one edge of the spec's rules, using the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int ow, s;
      ow = 1 << sw[k];
      s  = int'(sel_all) % ow;
      m_wrap[k] = 1'b0;
      if (rst) begin
        m_idx[k] = 0;
        m_cnt[k] = 0;
      end else if (!en) begin
        // idx and cnt hold
      end else if (!mode || load) begin
        m_idx[k] = s;
        m_cnt[k] = 0;
      end else if (m_cnt[k] == int'(div)) begin
        m_cnt[k]  = 0;
        m_wrap[k] = (m_idx[k] == ow - 1);
        m_idx[k]  = (m_idx[k] + 1) % ow;
      end else begin
        m_cnt[k] = (m_cnt[k] + 1) % 256;
      end
      m_y[k] = lines(k, !rst && en, m_idx[k]);
    end
  endtask

  task automatic compare_all();
    chk("y0", y0, m_y[0]);  chk("idx0", idx0, m_idx[0]);  chk("wrap0", wrap0, m_wrap[0]);
    chk("y1", y1, m_y[1]);  chk("idx1", idx1, m_idx[1]);  chk("wrap1", wrap1, m_wrap[1]);
    chk("y2", y2, m_y[2]);  chk("idx2", idx2, m_idx[2]);  chk("wrap2", wrap2, m_wrap[2]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  logic [3:0] dir_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int nw0, nw2;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel_all = 3'd0; div = 8'd0;
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 1'b0; m_y[k] = 64'd0;
    end

    // Reset for two cycles
    cycle(); cycle();
    chk("rst_y0_lit", y0, 64'h0);
    chk("rst_idx0_lit", idx0, 64'h0);
    chk("rst_y1_lit", y1, 64'hFF);
    chk("rst_wrap0_lit", wrap0, 64'h0);

    // Direct decode of sel 0..3
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_all = 3'(i);
      cycle();
      chk("direct_y0_lit", y0, dir_y[i]);
    end

    // Disable: lines go inactive, idx holds
    en = 1'b0;
    cycle();
    chk("dis_y0_lit", y0, 64'h0);
    chk("dis_idx0_lit", idx0, 64'h3);

    // Scan div=2 from a fresh reset: four steps in 12 cycles, one wrap
    rst = 1'b1; cycle(); rst = 1'b0;
    en = 1'b1; mode = 1'b1; div = 8'd2;
    nw0 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (wrap0) nw0++;
      if (i == 2) chk("scan_first_step_lit", idx0, 64'h1);
    end
    chk("scan_wraps_lit", nw0, 1);
    chk("scan_idx_end_lit", idx0, 64'h0);
    chk("scan_y0_end_lit", y0, 64'b0001);

    // Load on the same edge as a step from idx 3
    repeat (11) cycle();
    chk("pre_load_idx0_lit", idx0, 64'h3);
    load = 1'b1; sel_all = 3'd2;
    cycle();
    load = 1'b0;
    chk("load_idx0_lit", idx0, 64'h2);
    chk("load_wrap0_lit", wrap0, 64'h0);
    chk("load_y0_lit", y0, 64'b0100);
    cycle(); cycle();
    chk("load_hold_lit", idx0, 64'h2);
    cycle();
    chk("load_next_step_lit", idx0, 64'h3);

    // Enable pause holds idx and count
    en = 1'b0;
    repeat (5) cycle();
    chk("pause_y0_lit", y0, 64'h0);
    en = 1'b1;
    repeat (3) cycle();

    // div=0: step every cycle
    rst = 1'b1; cycle(); rst = 1'b0;
    div = 8'd0;
    nw0 = 0; nw2 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (wrap0) nw0++;
      if (wrap2) nw2++;
    end
    chk("div0_wraps0_lit", nw0, 2);
    chk("div0_wraps2_lit", nw2, 4);

    // Active-low 8-line instance with div=1
    rst = 1'b1; cycle(); rst = 1'b0;
    div = 8'd1;
    cycle();
    chk("al_first_lit", y1, 64'hFE);
    repeat (2) cycle();
    chk("al_step_lit", y1, 64'hFD);

    // Reset mid-scan
    rst = 1'b1; cycle();
    chk("midrst_y0_lit", y0, 64'h0);
    chk("midrst_wrap_lit", wrap0, 64'h0);
    rst = 1'b0;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      en      = ($urandom_range(0, 7) != 0);
      mode    = ($urandom_range(0, 5) != 0);
      load    = ($urandom_range(0, 15) == 0);
      sel_all = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0)
        div = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 15) == 0)
        div = 8'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
